// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - RES/NMI/BRK/IRQ entry sequencer beside the instruction decoder
//
// Arbitrates reset, NMI, BRK and IRQ at an instruction boundary and runs the
// entry sequence: dummy read, push PCH/PCL/P (reads for reset), fetch the
// vector, then pulse pc_load/sp_load/set_i.
//
// Ports:
//   clk, res (sync active-high), rdy (0 = freeze)
//   irq, nmi, brk_req, instr_boundary, i_flag     request / decoder inputs
//   pc_in, sp_in, status_in                       CPU state latched at start
//   data_in                                       memory read data
//   take, busy, kind                              sequence status
//   addr, data_out, rw                            bus
//   pc_load/pc_load_value, sp_load/sp_out, set_i  register updates at the end
module interrupt_sequencer #(
  parameter int              ADDR_W   = 16,
  parameter int              P_W      = 7,
  parameter int              B_BIT    = 4,
  parameter logic [ADDR_W-9:0] SP_PAGE = 'h01,
  parameter logic [15:0]     NMI_VEC  = 16'hFFFA,
  parameter logic [15:0]     RES_VEC  = 16'hFFFC,
  parameter logic [15:0]     IRQ_VEC  = 16'hFFFE,
  parameter bit              NMI_EDGE = 1'b1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              rdy,
  input  logic              irq,
  input  logic              nmi,
  input  logic              brk_req,
  input  logic              instr_boundary,
  input  logic              i_flag,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        sp_in,
  input  logic [P_W-1:0]    status_in,
  input  logic [7:0]        data_in,
  output logic              take,
  output logic              busy,
  output logic [1:0]        kind,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_out,
  output logic              rw,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_value,
  output logic              sp_load,
  output logic [7:0]        sp_out,
  output logic              set_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_DUMMY, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI
  } state_e;

  localparam logic [1:0] K_RES = 2'b00;
  localparam logic [1:0] K_NMI = 2'b01;
  localparam logic [1:0] K_IRQ = 2'b10;
  localparam logic [1:0] K_BRK = 2'b11;

  localparam logic [ADDR_W-1:0] NMI_V    = NMI_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] RES_V    = RES_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] IRQ_V    = IRQ_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_e              state_q, state_d;
  logic                rst_pend_q, rst_pend_d;
  logic                nmi_pend_q, nmi_pend_d;
  logic                nmi_s_q, nmi_prev_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          sp_q, sp_d;
  logic [P_W-1:0]      status_q, status_d;
  logic [1:0]          kind_q, kind_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;
  logic [7:0]          vec_lo_q, vec_lo_d;

  logic                nmi_edge, nmi_pend, req_any, use_nmi;
  logic [1:0]          kind_sel;
  logic [ADDR_W-1:0]   vec_sel;
  logic [7:0]          sp_m1, sp_m2, p_ext;

  // Edge detector runs every cycle regardless of rdy or sequence state.
  assign nmi_edge = nmi_s_q & ~nmi_prev_q;
  assign nmi_pend = NMI_EDGE ? nmi_pend_q : nmi;
  assign sp_m1    = sp_q - 8'd1;
  assign sp_m2    = sp_q - 8'd2;

  // Arbitration: RES > NMI > BRK > IRQ.
  always_comb begin
    req_any  = 1'b1;
    kind_sel = K_RES;
    if (rst_pend_q)            kind_sel = K_RES;
    else if (nmi_pend)         kind_sel = K_NMI;
    else if (brk_req)          kind_sel = K_BRK;
    else if (irq && !i_flag)   kind_sel = K_IRQ;
    else                       req_any  = 1'b0;
  end

  // A pending NMI hijacks an IRQ/BRK vector fetch; kind stays as it was.
  assign use_nmi = (kind_q != K_RES) && ((kind_q == K_NMI) || nmi_pend);
  assign vec_sel = (kind_q == K_RES) ? RES_V : (use_nmi ? NMI_V : IRQ_V);

  always_comb begin
    p_ext        = 8'(status_q);
    p_ext[B_BIT] = (kind_q == K_BRK);
  end

  always_comb begin
    state_d    = state_q;
    rst_pend_d = rst_pend_q;
    nmi_pend_d = NMI_EDGE ? (nmi_pend_q | nmi_edge) : nmi;
    pc_d       = pc_q;
    sp_d       = sp_q;
    status_d   = status_q;
    kind_d     = kind_q;
    vec_d      = vec_q;
    vec_lo_d   = vec_lo_q;

    take          = 1'b0;
    addr          = '0;
    data_out      = 8'h00;
    rw            = 1'b1;
    pc_load       = 1'b0;
    pc_load_value = '0;
    sp_load       = 1'b0;
    sp_out        = 8'h00;
    set_i         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rdy && (rst_pend_q || instr_boundary) && req_any) begin
          take     = 1'b1;
          state_d  = S_DUMMY;
          pc_d     = pc_in;
          sp_d     = sp_in;
          status_d = status_in;
          kind_d   = kind_sel;
          if (kind_sel == K_RES) rst_pend_d = 1'b0;
        end
      end
      S_DUMMY: begin
        addr = pc_q;
        if (rdy) state_d = S_PUSH_PCH;
      end
      S_PUSH_PCH: begin
        addr     = {SP_PAGE, sp_q};
        data_out = 8'(pc_q[ADDR_W-1:8]);
        rw       = (kind_q == K_RES);
        if (rdy) state_d = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        addr     = {SP_PAGE, sp_m1};
        data_out = pc_q[7:0];
        rw       = (kind_q == K_RES);
        if (rdy) state_d = S_PUSH_P;
      end
      S_PUSH_P: begin
        addr     = {SP_PAGE, sp_m2};
        data_out = p_ext;
        rw       = (kind_q == K_RES);
        if (rdy) state_d = S_VEC_LO;
      end
      S_VEC_LO: begin
        addr = vec_sel;
        if (rdy) begin
          vec_d    = vec_sel;
          vec_lo_d = data_in;
          // Consume the pending NMI; a coincident new edge still sets it.
          if (use_nmi) nmi_pend_d = NMI_EDGE ? nmi_edge : nmi;
          state_d = S_VEC_HI;
        end
      end
      S_VEC_HI: begin
        addr          = vec_q + ADDR_ONE;
        pc_load_value = {data_in[ADDR_W-9:0], vec_lo_q};
        sp_out        = sp_q - 8'd3;
        pc_load       = rdy;
        sp_load       = rdy;
        set_i         = rdy;
        if (rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!rdy) rw = 1'b1;

    if (res) begin
      take          = 1'b0;
      addr          = '0;
      data_out      = 8'h00;
      rw            = 1'b1;
      pc_load       = 1'b0;
      pc_load_value = '0;
      sp_load       = 1'b0;
      sp_out        = 8'h00;
      set_i         = 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE) && !res;
  assign kind = res ? K_RES : kind_q;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_s_q    <= 1'b0;
      nmi_prev_q <= 1'b0;
      pc_q       <= '0;
      sp_q       <= 8'h00;
      status_q   <= '0;
      kind_q     <= K_RES;
      vec_q      <= '0;
      vec_lo_q   <= 8'h00;
    end else begin
      nmi_s_q    <= nmi;
      nmi_prev_q <= nmi_s_q;
      nmi_pend_q <= nmi_pend_d;
      if (rdy) begin
        state_q    <= state_d;
        rst_pend_q <= rst_pend_d;
        pc_q       <= pc_d;
        sp_q       <= sp_d;
        status_q   <= status_d;
        kind_q     <= kind_d;
        vec_q      <= vec_d;
        vec_lo_q   <= vec_lo_d;
      end
    end
  end

endmodule
